// File: rtl/inst_rom_loader.sv
// Instruction ROM with a byte-serial image loader: bytes are packed big-endian
// into 32-bit words and written sequentially; fetches are served once complete.
module inst_rom_loader #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chipEnable,
  input  logic [31:0]           romAddr,
  output logic [31:0]           romInst,
  input  logic                  loadStart,
  input  logic                  loadValid,
  input  logic [7:0]            loadByte,
  input  logic                  loadLast,
  output logic                  loadReady,
  output logic                  romReady,
  output logic [ADDR_WIDTH:0]   wordCount
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  typedef enum logic {
    S_LOAD  = 1'b0,
    S_READY = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         wcount_q, wcount_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [31:0]           word_q, word_d;

  logic                  xfer_c;
  logic                  wr_en_c;
  logic [31:0]           wr_data_c;
  logic [ADDR_WIDTH-1:0] wr_addr_c;
  logic [ADDR_WIDTH-1:0] rd_idx_c;
  logic                  hit_c;
  logic                  unused_c;

  logic [31:0] mem [DEPTH];

  // Merge the incoming byte into the partial word at the slot picked by the byte counter
  always_comb begin
    xfer_c    = loadValid && (state_q == S_LOAD) && !loadStart;
    wr_addr_c = wcount_q[ADDR_WIDTH-1:0];
    case (bcnt_q)
      2'd0:    wr_data_c = {loadByte, 24'h0};
      2'd1:    wr_data_c = {word_q[31:24], loadByte, 16'h0};
      2'd2:    wr_data_c = {word_q[31:16], loadByte, 8'h0};
      default: wr_data_c = {word_q[31:8], loadByte};
    endcase
    wr_en_c = xfer_c && ((bcnt_q == 2'd3) || loadLast);
  end

  // Next-state: loadStart wins over any same-cycle transfer; a full memory ends the image
  always_comb begin
    state_d  = state_q;
    wcount_d = wcount_q;
    bcnt_d   = bcnt_q;
    word_d   = word_q;
    if (loadStart) begin
      state_d  = S_LOAD;
      wcount_d = '0;
      bcnt_d   = '0;
      word_d   = '0;
    end else if (xfer_c) begin
      word_d = wr_data_c;
      bcnt_d = bcnt_q + 2'd1;
      if (wr_en_c) begin
        bcnt_d   = '0;
        wcount_d = wcount_q + CW'(1);
        if (loadLast || (wcount_d == CW'(DEPTH))) begin
          state_d = S_READY;
        end
      end
    end
  end

  // Control state registers; reset drops any partial word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_LOAD;
      wcount_q <= '0;
      bcnt_q   <= '0;
      word_q   <= '0;
    end else begin
      state_q  <= state_d;
      wcount_q <= wcount_d;
      bcnt_q   <= bcnt_d;
      word_q   <= word_d;
    end
  end

  // Image storage; deliberately not reset so earlier words survive reload and reset
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_addr_c] <= wr_data_c;
    end
  end

  // Combinational fetch port; anything not served returns NOP
  always_comb begin
    rd_idx_c = romAddr[ADDR_WIDTH+1:2];
    hit_c    = chipEnable && (state_q == S_READY) &&
               (romAddr[31:ADDR_WIDTH+2] == '0);
    romInst  = hit_c ? mem[rd_idx_c] : 32'h0;
  end

  assign loadReady = (state_q == S_LOAD);
  assign romReady  = (state_q == S_READY);
  assign wordCount = wcount_q;
  assign unused_c  = ^romAddr[1:0];

endmodule

// File: tb/tb_inst_rom_loader.sv
// Scoreboard bench for inst_rom_loader: default-size instance plus a 4-word instance.
module tb_inst_rom_loader;

  logic        clk = 1'b0;
  logic        rst;

  logic        chipEnable, loadStart, loadValid, loadLast;
  logic [31:0] romAddr;
  logic [7:0]  loadByte;
  logic [31:0] romInst;
  logic        loadReady, romReady;
  logic [10:0] wordCount;

  logic        s_chipEnable, s_loadStart, s_loadValid, s_loadLast;
  logic [31:0] s_romAddr;
  logic [7:0]  s_loadByte;
  logic [31:0] s_romInst;
  logic        s_loadReady, s_romReady;
  logic [2:0]  s_wordCount;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] img[16];
  logic [31:0] m_buf;
  int          m_cnt;

  always #5 clk = ~clk;

  inst_rom_loader #(.ADDR_WIDTH(10)) u_dut (
    .clk(clk), .rst(rst), .chipEnable(chipEnable), .romAddr(romAddr),
    .romInst(romInst), .loadStart(loadStart), .loadValid(loadValid),
    .loadByte(loadByte), .loadLast(loadLast), .loadReady(loadReady),
    .romReady(romReady), .wordCount(wordCount)
  );

  inst_rom_loader #(.ADDR_WIDTH(2)) u_dut_small (
    .clk(clk), .rst(rst), .chipEnable(s_chipEnable), .romAddr(s_romAddr),
    .romInst(s_romInst), .loadStart(s_loadStart), .loadValid(s_loadValid),
    .loadByte(s_loadByte), .loadLast(s_loadLast), .loadReady(s_loadReady),
    .romReady(s_romReady), .wordCount(s_wordCount)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference packer: big-endian bytes into words, pushed to the scoreboard
  task automatic model_byte(input logic [7:0] b, input logic last);
    if (m_cnt == 0) m_buf = '0;
    m_buf[31 - 8*m_cnt -: 8] = b;
    m_cnt++;
    if (m_cnt == 4 || last) begin
      exp_q.push_back(m_buf);
      m_cnt = 0;
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    check("load_ready_before_byte", 32'(loadReady), 32'd1);
    loadValid = 1'b1;
    loadByte  = b;
    loadLast  = last;
    model_byte(b, last);
    cyc();
    loadValid = 1'b0;
    loadLast  = 1'b0;
  endtask

  task automatic pulse_start();
    loadStart = 1'b1;
    model_reset();
    cyc();
    loadStart = 1'b0;
  endtask

  // Fetch every expected word in order, popping the scoreboard
  task automatic fetch_all();
    int i;
    logic [31:0] e;
    i = 0;
    chipEnable = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      img[i] = e;
      romAddr = 32'(i * 4) | 32'($urandom_range(0, 3));
      #1;
      check($sformatf("fetch_word%0d", i), romInst, e);
      i++;
    end
    chipEnable = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    chipEnable = 1'b1; romAddr = '0; loadStart = 1'b0; loadValid = 1'b0;
    loadByte = '0; loadLast = 1'b0;
    s_chipEnable = 1'b0; s_romAddr = '0; s_loadStart = 1'b0; s_loadValid = 1'b0;
    s_loadByte = '0; s_loadLast = 1'b0;
    m_cnt = 0; m_buf = '0;

    // Reset state
    #12;
    check("rst_rom_ready", 32'(romReady), 32'd0);
    check("rst_load_ready", 32'(loadReady), 32'd1);
    check("rst_word_count", 32'(wordCount), 32'd0);
    check("rst_rom_inst", romInst, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    chipEnable = 1'b0;
    cyc();

    // Two full words, last on the 8th byte
    send_byte(8'h24, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h34, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'hFF, 1'b1);
    check("t1_word_count", 32'(wordCount), 32'd2);
    check("t1_rom_ready", 32'(romReady), 32'd1);
    check("t1_load_ready", 32'(loadReady), 32'd0);
    check("t1_sb_w0", exp_q[0], 32'h24000001);
    check("t1_sb_w1", exp_q[1], 32'h340100FF);
    fetch_all();

    // Short final word zero-fills its low bytes
    pulse_start();
    check("t2_rom_ready_after_start", 32'(romReady), 32'd0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b1);
    check("t2_word_count", 32'(wordCount), 32'd1);
    check("t2_rom_ready", 32'(romReady), 32'd1);
    check("t2_sb_w0", exp_q[0], 32'hAABB0000);
    fetch_all();

    // Random byte stream with random valid gaps
    pulse_start();
    for (int k = 0; k < 14; k++) begin
      repeat ($urandom_range(0, 2)) cyc();
      send_byte(8'($urandom), (k == 13));
    end
    check("t3_word_count", 32'(wordCount), 32'd4);
    check("t3_sb_depth", 32'(exp_q.size()), 32'd4);
    // Bytes offered in READY must be ignored
    for (int k = 0; k < 3; k++) begin
      loadValid = 1'b1; loadByte = 8'($urandom); loadLast = k[0];
      cyc();
    end
    loadValid = 1'b0; loadLast = 1'b0;
    check("t3_word_count_ready", 32'(wordCount), 32'd4);
    fetch_all();
    chipEnable = 1'b1;
    romAddr = 32'd6;
    #1 check("t3_addr6_word1", romInst, img[1]);
    romAddr = 32'h0000_1000;
    #1 check("t3_out_of_range", romInst, 32'h0);
    chipEnable = 1'b0;
    romAddr = 32'd4;
    #1 check("t3_chip_disabled", romInst, 32'h0);
    @(negedge clk);

    // loadStart coinciding with the 4th byte of a word
    pulse_start();
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
    loadStart = 1'b1; loadValid = 1'b1; loadByte = 8'h99;
    model_reset();
    cyc();
    loadStart = 1'b0; loadValid = 1'b0;
    check("t4_word_count_cleared", 32'(wordCount), 32'd0);
    check("t4_load_ready", 32'(loadReady), 32'd1);
    send_byte(8'hDE, 1'b0); send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0); send_byte(8'hEF, 1'b1);
    check("t4_word_count", 32'(wordCount), 32'd1);
    check("t4_sb_w0", exp_q[0], 32'hDEADBEEF);
    fetch_all();
    chipEnable = 1'b1; romAddr = 32'd0;
    #1 check("t4_ready_fetch", romInst, img[0]);
    @(negedge clk);
    pulse_start();
    check("t4_restart_rom_ready", 32'(romReady), 32'd0);
    check("t4_restart_rom_inst", romInst, 32'h0);
    chipEnable = 1'b0;

    // Asynchronous reset mid-word
    send_byte(8'hC0, 1'b0); send_byte(8'hC1, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("t5_rst_rom_ready", 32'(romReady), 32'd0);
    check("t5_rst_word_count", 32'(wordCount), 32'd0);
    check("t5_rst_load_ready", 32'(loadReady), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    cyc();
    send_byte(8'h01, 1'b0); send_byte(8'h23, 1'b0);
    send_byte(8'h45, 1'b0); send_byte(8'h67, 1'b1);
    check("t5_word_count", 32'(wordCount), 32'd1);
    check("t5_sb_w0", exp_q[0], 32'h01234567);
    fetch_all();

    // Small instance: 17 bytes offered back to back, memory fills at 16
    for (int k = 0; k < 17; k++) begin
      if (k == 16) check("t6_ready_drops_at_full", 32'(s_loadReady), 32'd0);
      s_loadValid = 1'b1;
      s_loadByte  = 8'(k * 16 + 3);
      if (k < 16) model_byte(8'(k * 16 + 3), 1'b0);
      cyc();
    end
    s_loadValid = 1'b0;
    check("t6_word_count", 32'(s_wordCount), 32'd4);
    check("t6_load_ready", 32'(s_loadReady), 32'd0);
    check("t6_rom_ready", 32'(s_romReady), 32'd1);
    check("t6_sb_depth", 32'(exp_q.size()), 32'd4);
    s_chipEnable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      s_romAddr = 32'(i * 4);
      #1 check($sformatf("t6_fetch_word%0d", i), s_romInst, e);
    end
    s_romAddr = 32'h10;
    #1 check("t6_out_of_range", s_romInst, 32'h0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard bound on run length
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
